ps2_key_tracker: RTL

Parametrised PS/2 set-2 scan-code decoder for the game front end. It sits between `PS2_Controller` (its `received_data` / `received_data_en` outputs) and game logic. It resolves E0 (extended), F0 (break) and E1 (Pause) sequences and suppresses typematic repeats. It keeps a held-key bitmap for a configurable set of game keys and queues every make/break event in an event FIFO with a valid/ready handshake.

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/key_event_fifo.sv | 81 ++++++++
 rtl/ps2_key_tracker.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 key tracker: decoder states,
// protocol byte values and the layout of a queued key event.
package ps2_pkg;

    // Decoder states. IDLE waits for a new scan code. EXT and BRK hold a
    // pending E0 or F0 prefix. EXT_BRK holds E0 F0. SKIP swallows the Pause tail.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } ps2_state_e;

    // Prefix bytes
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Keyboard responses and error codes; they never form a key event
    localparam logic [7:0] PS2_ERR_LO = 8'h00;
    localparam logic [7:0] PS2_ERR_HI = 8'hFF;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;

    // After E1, Pause sends 7 more bytes: 14 77 E1 F0 14 F0 77
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    // One queued event: {ext, make, code}
    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] code;
    } key_event_t;

    localparam int EV_W = 10;

    // True for bytes that are dropped when they arrive with no prefix pending
    function automatic logic is_response(input logic [7:0] b);
        return (b == PS2_ERR_LO) || (b == PS2_ERR_HI) || (b == PS2_BAT_OK) ||
               (b == PS2_ACK)    || (b == PS2_RESEND) || (b == PS2_ECHO);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO with first-word fall-through. The head word is
// presented while valid_o is high and is consumed on valid_o && pop_ready_i.
// If a push arrives while the FIFO is full and nothing is popped, the word is
// dropped and a sticky overflow flag is set.
module key_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_ready_i,
    input  logic                     ovf_clr_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             ovf_q;

    logic empty, full, pop, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = !empty && pop_ready_i;
    // A full FIFO can still take a word when the head leaves in the same cycle
    assign push_ok = push_i && (!full || pop);

    // Storage write
    // NOTE: the storage array has no reset. Its contents only matter
    // below count_q, and the head output is gated to zero while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers, occupancy and sticky overflow
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples values from before the edge, with no race between blocks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
            // A new drop beats a clear in the same cycle
            if (push_i && !push_ok) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign valid_o    = !empty;
    assign data_o     = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code decoder for the game front end. It resolves E0, F0
// and E1 sequences, suppresses typematic repeats, keeps a held-key bitmap
// for a configurable set of game keys and queues make/break events.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                      NUM_KEYS    = 8,
    parameter logic [9*NUM_KEYS-1:0]   KEY_CODES   = '0,
    parameter int                      FIFO_DEPTH  = 8,
    parameter int                      TIMEOUT_CYC = 1_000_000
) (
    input  logic                           CLOCK_50,
    input  logic                           Reset,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_en,
    input  logic                           ev_ready,
    input  logic                           ovf_clr,
    output logic [NUM_KEYS-1:0]            key_down,
    output logic                           any_down,
    output logic                           ev_valid,
    output logic [7:0]                     ev_code,
    output logic                           ev_ext,
    output logic                           ev_make,
    output logic                           ev_overflow,
    output logic [$clog2(FIFO_DEPTH):0]    ev_count
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ps2_state_e         state_q, state_d;
    logic [2:0]         skip_q, skip_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [NUM_KEYS-1:0] key_down_q, key_down_d;
    logic [8:0]         last_make_q, last_make_d;

    // Decoder outputs for the current byte
    logic               dec_make, dec_brk, dec_ext;
    logic [8:0]         dec_key;

    // Key matcher results
    logic [NUM_KEYS-1:0] hit;
    logic               tracked, held;

    logic               ev_push;
    key_event_t         push_ev, head_ev;

    // Prefix decoder: advance the FSM on each byte and flag complete make/break codes
    // NOTE: every signal written here gets a default first. Without one, a
    // path that skips an assignment would infer a latch.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        dec_make = 1'b0;
        dec_brk  = 1'b0;
        dec_ext  = 1'b0;
        if (rx_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_data == PS2_BRK) begin
                        state_d = ST_BRK;
                    end else if (rx_data == PS2_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = PAUSE_TAIL;
                    end else if (!is_response(rx_data)) begin
                        dec_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_data == PS2_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data != PS2_EXT) begin
                        dec_make = 1'b1;
                        dec_ext  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    // A second prefix after F0 is a protocol error: drop it and resync
                    state_d = ST_IDLE;
                    dec_ext = (state_q == ST_EXT_BRK);
                    if ((rx_data != PS2_BRK) && (rx_data != PS2_EXT)) begin
                        dec_brk = 1'b1;
                    end
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if ((state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1))) begin
            // Abandon a half-received sequence after a long silence
            state_d = ST_IDLE;
            skip_d  = '0;
        end
    end

    // Idle counter: counts cycles since the last byte while a prefix is pending
    always_comb begin
        tmo_d = tmo_q;
        if (rx_en || (state_q == ST_IDLE)) begin
            tmo_d = '0;
        end else if (tmo_q != TW'(TIMEOUT_CYC)) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    assign dec_key = {dec_ext, rx_data};

    // Key matcher: compare the decoded key against every table entry in parallel
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            hit[i] = (KEY_CODES[9*i +: 9] == dec_key);
        end
    end

    assign tracked = |hit;
    assign held    = |(hit & key_down_q);

    // Event filter: repeat suppression, bitmap update and FIFO push request
    always_comb begin
        key_down_d  = key_down_q;
        last_make_d = last_make_q;
        ev_push     = 1'b0;
        if (dec_make) begin
            // Tracked keys repeat while their bit is set. Untracked keys repeat
            // while they are still the most recent make.
            if (tracked ? !held : (dec_key != last_make_q)) begin
                key_down_d  = key_down_q | hit;
                last_make_d = dec_key;
                ev_push     = 1'b1;
            end
        end else if (dec_brk) begin
            key_down_d = key_down_q & ~hit;
            if (last_make_q == dec_key) begin
                last_make_d = '0;
            end
            ev_push = 1'b1;
        end
    end

    assign push_ev = '{ext: dec_ext, make: dec_make, code: rx_data};

    // Decoder, timeout and key state registers
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            skip_q      <= '0;
            tmo_q       <= '0;
            key_down_q  <= '0;
            last_make_q <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            tmo_q       <= tmo_d;
            key_down_q  <= key_down_d;
            last_make_q <= last_make_d;
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk_i       (CLOCK_50),
        .rst_i       (Reset),
        .push_i      (ev_push),
        .push_data_i (push_ev),
        .pop_ready_i (ev_ready),
        .ovf_clr_i   (ovf_clr),
        .valid_o     (ev_valid),
        .data_o      (head_ev),
        .count_o     (ev_count),
        .overflow_o  (ev_overflow)
    );

    assign key_down = key_down_q;
    assign any_down = |key_down_q;
    assign ev_code  = head_ev.code;
    assign ev_ext   = head_ev.ext;
    assign ev_make  = head_ev.make;

endmodule
